// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between a UART receiver and its consumer: first-word-fall-through, sticky overflow.
// Optional dropped-word counter (drop_cnt) is built when UART_RX_FIFO_DROP_CNT_EN is defined.
module uart_rx_fifo #(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [BIT_WIDTH-1:0]     in_data,
    input  logic                     in_err,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BIT_WIDTH-1:0]     out_data,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clr_overflow
`ifdef UART_RX_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = BIT_WIDTH + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               valid_q, valid_d;
    logic               overflow_q, overflow_d;
    logic               push, pop, drop;
    logic [ENTRY_W-1:0] head;

    // Handshake qualification; a pop frees a slot so a full FIFO can still accept.
    always_comb begin
        pop  = valid_q && out_ready;
        push = in_valid && (!full_q || pop);
        drop = in_valid && full_q && !pop;
    end

    // Next-state for pointers, occupancy and flags.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
        valid_d = !empty_d;
        // A drop in the same cycle as a clear wins so no loss goes unreported.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; contents are only observed while out_valid is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {in_err, in_data};
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_overflow) begin
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    // Without the counter, overflow alone reports dropped words.
`endif

    assign head      = mem_q[rptr_q];
    assign out_data  = head[BIT_WIDTH-1:0];
    assign out_err   = head[ENTRY_W-1];
    assign out_valid = valid_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign overflow  = overflow_q;

endmodule
